// File: rtl/prog_rom_if.sv
// Fetch and program-load signals between the CPU/loader (master) and the program store (slave).
interface prog_rom_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8
);
   logic [ADDR_W-1:0] addr_bus;
   logic [DATA_W-1:0] data_bus;
   logic              cpu_hold;
   logic              load_start;
   logic [ADDR_W-1:0] load_base;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              load_done;
   logic [ADDR_W:0]   load_count;

   modport master (
      output addr_bus, load_start, load_base, load_valid, load_data, load_last,
      input  data_bus, cpu_hold, load_ready, load_done, load_count
   );

   modport slave (
      input  addr_bus, load_start, load_base, load_valid, load_data, load_last,
      output data_bus, cpu_hold, load_ready, load_done, load_count
   );
endinterface

// File: rtl/prog_rom.sv
// Program store: serves CPU byte fetches with one-cycle latency and accepts streamed program
// loads, stalling the CPU until the new contents are visible on the fetch port.
module prog_rom #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4096  // must equal 2**ADDR_W so the pointer wraps naturally
) (
   input logic       clk,
   input logic       rst,
   prog_rom_if.slave bus
);

   typedef enum logic [1:0] {StServe, StLoad, StFlush} state_e;

   localparam logic [ADDR_W:0] LastCount = (ADDR_W+1)'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept;

   assign accept = (state_q == StLoad) && bus.load_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StServe;
         ptr_q   <= '0;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         // FLUSH reads too, so SERVE starts with data already reflecting the new program.
         if (state_q != StLoad) begin
            data_q <= mem[bus.addr_bus];
         end
      end
   end

   // Storage has no reset: program contents survive reset and aborted loads.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[ptr_q] <= bus.load_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StServe: if (bus.load_start) state_d = StLoad;
         StLoad:  if (accept && (bus.load_last || count_q == LastCount)) state_d = StFlush;
         StFlush: state_d = StServe;
         default: state_d = StServe;
      endcase
   end

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      if (state_q == StServe && bus.load_start) begin
         ptr_d   = bus.load_base;
         count_d = '0;
      end else if (accept) begin
         ptr_d   = ptr_q + 1'b1;
         count_d = count_q + 1'b1;
      end
   end

   always_comb begin
      bus.cpu_hold   = 1'b0;
      bus.load_ready = 1'b0;
      bus.load_done  = 1'b0;
      unique case (state_q)
         StLoad: begin
            bus.cpu_hold   = 1'b1;
            bus.load_ready = 1'b1;
         end
         StFlush: begin
            bus.cpu_hold  = 1'b1;
            bus.load_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.data_bus   = data_q;
   assign bus.load_count = count_q;

   a_count_bound: assert property (@(posedge clk) disable iff (!rst)
      count_q <= LastCount + 1'b1);

   a_flush_single: assert property (@(posedge clk) disable iff (!rst)
      state_q == StFlush |=> state_q == StServe);

endmodule
